fft_twiddle_sequencer: RTL and testbench

Controller that sequences the 8-lane twiddle complex multiplier through all stages of a 64-point radix-2 FFT. Each cycle it issues one 8-butterfly block by driving the multiplier's isValid/start/step inputs, and tracks in-flight results against the multiplier's resultValid. It drains in-flight results at every stage boundary, because stage s+1 consumes stage s outputs. It sits between the top-level FFT control and the multiplier; stage/block outputs feed the operand address generator.

---
 rtl/fft_twiddle_sequencer_if.sv | 23 ++
 rtl/fft_twiddle_sequencer.sv | 118 +++++++++++
 tb/tb_fft_twiddle_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_twiddle_sequencer_if.sv
// Handshake bundle between the twiddle sequencer and the 8-lane twiddle
// complex multiplier: issue strobe plus twiddle start/step, and the
// multiplier's per-block result strobe coming back.
interface fft_twiddle_sequencer_if;
  logic       mult_isValid;
  logic [5:0] mult_start;
  logic [5:0] mult_step;
  logic       mult_resultValid;

  modport master (
    output mult_isValid,
    output mult_start,
    output mult_step,
    input  mult_resultValid
  );

  modport slave (
    input  mult_isValid,
    input  mult_start,
    input  mult_step,
    output mult_resultValid
  );
endinterface

// File: rtl/fft_twiddle_sequencer.sv
// Sequences the 8-lane twiddle multiplier through the 6 stages of a 64-point
// radix-2 FFT: 4 blocks of 8 butterflies per stage, one block per cycle,
// with an outstanding-result limit and a full drain between stages.
module fft_twiddle_sequencer #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int NUM_STAGES      = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           operands_ready,
  fft_twiddle_sequencer_if.master        mult,
  output logic [2:0]                     stage,
  output logic [1:0]                     block,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  localparam logic [3:0] OUT_MAX    = 4'(MAX_OUTSTANDING);
  localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

  state_t     r_state;
  logic [2:0] r_stage;
  logic [1:0] r_block;
  logic [3:0] r_outstanding;
  logic       r_done;
  logic       r_err;

  logic       w_issue;
  logic       w_rv;
  logic [5:0] w_start;
  logic [5:0] w_step;

  assign w_rv    = mult.mult_resultValid;
  assign w_issue = (r_state == ISSUE) && operands_ready && (r_outstanding < OUT_MAX);

  // Twiddle index for lane 0 and per-lane increment; butterflies are ordered
  // twiddle-major, so early stages share one twiddle across a whole block.
  always_comb begin
    w_start = 6'd0;
    w_step  = 6'd0;
    case (r_stage)
      3'd1:    w_start = {1'b0, r_block[1], 4'b0000};
      3'd2:    w_start = {1'b0, r_block, 3'b000};
      3'd3:    w_step  = 6'd4;
      3'd4: begin
        w_start = {1'b0, r_block[0], 4'b0000};
        w_step  = 6'd2;
      end
      3'd5: begin
        w_start = {1'b0, r_block, 3'b000};
        w_step  = 6'd1;
      end
      default: ;
    endcase
  end

  // Control FSM plus outstanding-result tracking and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_stage       <= 3'd0;
      r_block       <= 2'd0;
      r_outstanding <= 4'd0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= ISSUE;
          r_stage <= 3'd0;
          r_block <= 2'd0;
        end
        ISSUE: if (w_issue) begin
          r_block <= r_block + 2'd1;
          if (r_block == 2'd3) r_state <= DRAIN;
        end
        // Next stage reads this stage's outputs, so wait for every result.
        DRAIN: if (r_outstanding == 4'd0) begin
          if (r_stage == LAST_STAGE) begin
            r_state <= FIN;
            r_done  <= 1'b1;
          end else begin
            r_stage <= r_stage + 3'd1;
            r_state <= ISSUE;
          end
        end
        FIN: begin
          r_stage <= 3'd0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Issue and return in the same cycle cancel out.
      if (w_issue && !w_rv)
        r_outstanding <= r_outstanding + 4'd1;
      else if (!w_issue && w_rv) begin
        if (r_outstanding != 4'd0) r_outstanding <= r_outstanding - 4'd1;
        else                       r_err         <= 1'b1;
      end
    end
  end

  assign mult.mult_isValid = w_issue;
  assign mult.mult_start   = w_start;
  assign mult.mult_step    = w_step;
  assign stage             = r_stage;
  assign block             = r_block;
  assign busy              = (r_state != IDLE);
  assign done              = r_done;
  assign err               = r_err;

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
// Directed bench for fft_twiddle_sequencer: reset, full pass, backpressure,
// outstanding limit, simultaneous issue/return, stray result, mid-pass reset.
module tb_fft_twiddle_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, operands_ready;
  logic [2:0] stage;
  logic [1:0] block;
  logic       busy, done, err;

  logic       start2, ready2;
  logic [2:0] stage2;
  logic [1:0] block2;
  logic       busy2, done2, err2;

  fft_twiddle_sequencer_if bus ();
  fft_twiddle_sequencer_if bus2 ();

  fft_twiddle_sequencer #(.MAX_OUTSTANDING(4), .NUM_STAGES(6)) u_dut (
    .clk(clk), .rst(rst), .start(start), .operands_ready(operands_ready),
    .mult(bus.master), .stage(stage), .block(block), .busy(busy),
    .done(done), .err(err));

  // Second instance with a tighter limit so the limit bites mid-stage.
  fft_twiddle_sequencer #(.MAX_OUTSTANDING(2), .NUM_STAGES(6)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .operands_ready(ready2),
    .mult(bus2.master), .stage(stage2), .block(block2), .busy(busy2),
    .done(done2), .err(err2));

  int checks = 0;
  int errors = 0;

  int exp_start [24] = '{0,0,0,0,  0,0,16,16,  0,8,16,24,
                         0,0,0,0,  0,16,0,16,  0,8,16,24};
  int exp_step  [6]  = '{0,0,0,4,2,1};

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; operands_ready = 1'b0; bus.mult_resultValid = 1'b0;
    start2 = 1'b0; ready2 = 1'b0; bus2.mult_resultValid = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || bus.mult_isValid !== 1'b0 ||
        stage !== 3'd0 || block !== 2'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b err=%b isValid=%b stage=%0d block=%0d, want all 0",
               busy, done, err, bus.mult_isValid, stage, block);
    end
  endtask

  // Full pass with results returning one cycle after each issue; optional
  // 5-cycle operand stall once stage 2 reaches block 2.
  task automatic run_pass(input bit bp, input string name);
    int  n_iss = 0, n_done = 0, bp_cnt = 0;
    bit  prev = 1'b0, finished = 1'b0;
    do_reset;
    operands_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      bus.mult_resultValid = prev;
      operands_ready = !(bp && n_iss == 10 && bp_cnt < 5);
      #1;
      if (!operands_ready) begin
        bp_cnt++;
        checks++;
        if (bus.mult_isValid !== 1'b0 || stage !== 3'd2 || block !== 2'd2) begin
          errors++;
          $display("FAIL %s stall: isValid=%b stage=%0d block=%0d, want 0/2/2",
                   name, bus.mult_isValid, stage, block);
        end
      end
      if (bus.mult_isValid === 1'b1) begin
        if (n_iss < 24) begin
          checks++;
          if (bus.mult_start !== 6'(exp_start[n_iss]) || bus.mult_step !== 6'(exp_step[n_iss/4]) ||
              stage !== 3'(n_iss/4) || block !== 2'(n_iss%4)) begin
            errors++;
            $display("FAIL %s issue %0d: start=%0d step=%0d stage=%0d block=%0d, want %0d %0d %0d %0d",
                     name, n_iss, bus.mult_start, bus.mult_step, stage, block,
                     exp_start[n_iss], exp_step[n_iss/4], n_iss/4, n_iss%4);
          end
        end
        n_iss++;
      end
      prev = bus.mult_isValid;
      if (done === 1'b1) begin n_done++; finished = 1'b1; end
      tick;
      if (finished) break;
    end
    bus.mult_resultValid = 1'b0;
    repeat (3) begin
      #1;
      if (done === 1'b1) n_done++;
      if (bus.mult_isValid === 1'b1) n_iss++;
      tick;
    end
    checks++;
    if (n_iss != 24 || n_done != 1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s end: issues=%0d done_pulses=%0d busy=%b err=%b, want 24 1 0 0",
               name, n_iss, n_done, busy, err);
    end
    if (bp) begin
      checks++;
      if (bp_cnt != 5) begin
        errors++;
        $display("FAIL %s stall_cycles: got %0d, want 5", name, bp_cnt);
      end
    end
  endtask

  task automatic test_full_pass;
    run_pass(1'b0, "full_pass");
  endtask

  task automatic test_backpressure;
    run_pass(1'b1, "backpressure");
  endtask

  task automatic test_outstanding_limit;
    int n = 0;
    do_reset;
    operands_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
    repeat (8) begin
      #1;
      if (bus.mult_isValid === 1'b1) n++;
      tick;
    end
    checks++;
    if (n != 4 || bus.mult_isValid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL limit4: issues=%0d isValid=%b busy=%b, want 4 0 1", n, bus.mult_isValid, busy);
    end
    // Limit of 2 stalls in the middle of stage 0.
    n = 0;
    ready2 = 1'b1; start2 = 1'b1; tick; start2 = 1'b0;
    repeat (6) begin
      #1;
      if (bus2.mult_isValid === 1'b1) n++;
      tick;
    end
    checks++;
    if (n != 2 || bus2.mult_isValid !== 1'b0 || block2 !== 2'd2) begin
      errors++;
      $display("FAIL limit2_stall: issues=%0d isValid=%b block=%0d, want 2 0 2", n, bus2.mult_isValid, block2);
    end
    bus2.mult_resultValid = 1'b1; #1;
    checks++;
    if (bus2.mult_isValid !== 1'b0) begin
      errors++;
      $display("FAIL limit2_rv_cycle: isValid=%b, want 0", bus2.mult_isValid);
    end
    tick; bus2.mult_resultValid = 1'b0; #1;
    checks++;
    if (bus2.mult_isValid !== 1'b1 || block2 !== 2'd2 || bus2.mult_start !== 6'd0) begin
      errors++;
      $display("FAIL limit2_resume: isValid=%b block=%0d start=%0d, want 1 2 0",
               bus2.mult_isValid, block2, bus2.mult_start);
    end
    tick;
  endtask

  task automatic test_simultaneous;
    do_reset;
    operands_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
    repeat (3) begin #1; tick; end
    bus.mult_resultValid = 1'b1; #1;
    checks++;
    if (bus.mult_isValid !== 1'b1 || block !== 2'd3) begin
      errors++;
      $display("FAIL simul_issue: isValid=%b block=%0d, want 1 3", bus.mult_isValid, block);
    end
    tick;
    // Outstanding should now be 3: two returns must not end the drain.
    tick; tick;
    bus.mult_resultValid = 1'b0; #1;
    checks++;
    if (stage !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL simul_drain_hold: stage=%0d busy=%b, want 0 1", stage, busy);
    end
    tick;
    bus.mult_resultValid = 1'b1; #1; tick;
    bus.mult_resultValid = 1'b0; #1; tick;
    checks++;
    if (stage !== 3'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL simul_drain_exit: stage=%0d err=%b, want 1 0", stage, err);
    end
  endtask

  task automatic test_stray_result;
    do_reset;
    bus.mult_resultValid = 1'b1; #1; tick;
    bus.mult_resultValid = 1'b0; #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL stray_err_set: err=%b, want 1", err);
    end
    repeat (3) tick;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_err_hold: err=%b busy=%b, want 1 0", err, busy);
    end
  endtask

  task automatic test_reset_mid_pass;
    bit prev = 1'b0, found = 1'b0;
    int n = 0;
    do_reset;
    operands_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (stage === 3'd3 && block === 2'd2) begin found = 1'b1; break; end
      bus.mult_resultValid = prev; #1;
      prev = bus.mult_isValid;
      tick;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midrst_reach: stage=%0d block=%0d, want 3 2", stage, block);
    end
    rst = 1'b1; bus.mult_resultValid = 1'b0; #1; tick; rst = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || stage !== 3'd0 || block !== 2'd0 || bus.mult_isValid !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b stage=%0d block=%0d isValid=%b err=%b, want 0 0 0 0 0",
               busy, stage, block, bus.mult_isValid, err);
    end
    prev = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      bus.mult_resultValid = prev; #1;
      if (bus.mult_isValid === 1'b1) begin
        checks++;
        if (bus.mult_start !== 6'd0 || bus.mult_step !== 6'd0 || stage !== 3'd0 || block !== 2'(n)) begin
          errors++;
          $display("FAIL midrst_restart %0d: start=%0d step=%0d stage=%0d block=%0d, want 0 0 0 %0d",
                   n, bus.mult_start, bus.mult_step, stage, block, n);
        end
        n++;
      end
      prev = bus.mult_isValid;
      tick;
    end
    bus.mult_resultValid = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL midrst_restart_count: issues=%0d, want 4", n);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; operands_ready = 1'b0; bus.mult_resultValid = 1'b0;
    start2 = 1'b0; ready2 = 1'b0; bus2.mult_resultValid = 1'b0;
    test_reset;
    test_full_pass;
    test_backpressure;
    test_outstanding_limit;
    test_simultaneous;
    test_stray_result;
    test_reset_mid_pass;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
